jtpang_objdma: RTL and testbench

- Object DMA controller for the Pang-family main board, directly downstream of the main CPU block's dma_go strobe and bus-sharing pins.
- On a CPU DMA request it takes the Z80 bus (busrq_n/busak_n), copies LEN bytes of object attribute data from the video RAM into the object line-buffer RAM, then releases the bus.
- Its output feeds the object renderer.

---
 rtl/jtpang_pkg.sv | 16 +
 rtl/jtpang_objdma_edge.sv | 42 ++++
 rtl/jtpang_objdma.sv | 166 ++++++++++++++++
 tb/tb_jtpang_objdma.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtpang_pkg.sv
// Shared definitions for the Pang object DMA and the object renderer:
// controller state encoding and default transfer geometry.
package jtpang_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT_ACK = 3'd1;
    localparam state_t ST_READ     = 3'd2;
    localparam state_t ST_WRITE    = 3'd3;
    localparam state_t ST_RELEASE  = 3'd4;

    localparam int          OBJ_LEN      = 512;
    localparam logic [11:0] OBJ_SRC_BASE = 12'h000;

endpackage

// File: rtl/jtpang_objdma_edge.sv
// dma_go rising-edge detector with a pending flag. The flag is set on an
// edge (full clk rate) and cleared by the controller; set wins over clear.
module jtpang_objdma_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic clr,
    output logic pending
);

    logic din_q, din_d;
    logic pend_q, pend_d;
    logic rise_s;

    assign rise_s  = din & ~din_q;
    assign pending = pend_q;

    // next-state: delayed input copy and pending flag with set priority
    always_comb begin
        din_d  = din;
        pend_d = pend_q;
        if (rise_s) begin
            pend_d = 1'b1;
        end else if (clr) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // edge/pending registers, clocked every clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            din_q  <= din_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/jtpang_objdma.sv
// Object DMA: on a dma_go edge, takes the Z80 bus and copies LEN bytes from
// video RAM into the object line buffer at RD_LAT+1 cen ticks per byte.
module jtpang_objdma
    import jtpang_pkg::*;
#(
    parameter int              AW       = 12,
    parameter int              BW       = 9,
    parameter int              LEN      = OBJ_LEN,
    parameter logic [AW-1:0]   SRC_BASE = AW'(OBJ_SRC_BASE),
    parameter int              RD_LAT   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          dma_go,
    input  logic          busak_n,
    output logic          busrq_n,
    output logic          src_cs,
    output logic [AW-1:0] src_addr,
    input  logic [7:0]    src_dout,
    output logic [BW-1:0] obj_addr,
    output logic [7:0]    obj_din,
    output logic          obj_we,
    output logic          busy
);

    localparam logic [BW-1:0] CNT_LAST = BW'(LEN - 1);
    localparam logic [BW-1:0] CNT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] SRC_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    LAT_LAST = 2'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [1:0]    lat_q, lat_d;
    logic [AW-1:0] src_addr_q, src_addr_d;
    logic          src_cs_q, src_cs_d;
    logic [BW-1:0] obj_addr_q, obj_addr_d;
    logic [7:0]    obj_din_q, obj_din_d;
    logic          obj_we_q, obj_we_d;
    logic          busrq_n_q, busrq_n_d;
    logic          busy_q, busy_d;
    logic          pending_s, clr_s;

    jtpang_objdma_edge u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (dma_go),
        .clr     (clr_s),
        .pending (pending_s)
    );

    assign busrq_n  = busrq_n_q;
    assign src_cs   = src_cs_q;
    assign src_addr = src_addr_q;
    assign obj_addr = obj_addr_q;
    assign obj_din  = obj_din_q;
    assign obj_we   = obj_we_q;
    assign busy     = busy_q;

    // transfer FSM; obj_we defaults low so it is a single-clk pulse
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        src_addr_d = src_addr_q;
        src_cs_d   = src_cs_q;
        obj_addr_d = obj_addr_q;
        obj_din_d  = obj_din_q;
        obj_we_d   = 1'b0;
        busrq_n_d  = busrq_n_q;
        busy_d     = busy_q;
        clr_s      = 1'b0;
        if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (pending_s) begin
                        clr_s     = 1'b1;
                        busy_d    = 1'b1;
                        busrq_n_d = 1'b0;
                        state_d   = ST_WAIT_ACK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!busak_n) begin
                        cnt_d      = '0;
                        lat_d      = 2'd0;
                        src_addr_d = SRC_BASE;
                        src_cs_d   = 1'b1;
                        state_d    = ST_READ;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
                ST_READ: begin
                    if (lat_q == LAT_LAST) begin
                        obj_din_d  = src_dout;
                        obj_addr_d = cnt_q;
                        obj_we_d   = 1'b1;
                        src_cs_d   = 1'b0;
                        state_d    = ST_WRITE;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == CNT_LAST) begin
                        busrq_n_d = 1'b1;
                        state_d   = ST_RELEASE;
                    end else begin
                        cnt_d      = cnt_q + CNT_ONE;
                        src_addr_d = src_addr_q + SRC_ONE;
                        lat_d      = 2'd0;
                        src_cs_d   = 1'b1;
                        state_d    = ST_READ;
                    end
                end
                ST_RELEASE: begin
                    if (busak_n) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    busrq_n_d = 1'b1;
                    src_cs_d  = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // state and output registers; reset drops the bus request at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lat_q      <= 2'd0;
            src_addr_q <= SRC_BASE;
            src_cs_q   <= 1'b0;
            obj_addr_q <= '0;
            obj_din_q  <= 8'h00;
            obj_we_q   <= 1'b0;
            busrq_n_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            src_addr_q <= src_addr_d;
            src_cs_q   <= src_cs_d;
            obj_addr_q <= obj_addr_d;
            obj_din_q  <= obj_din_d;
            obj_we_q   <= obj_we_d;
            busrq_n_q  <= busrq_n_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: default instance (LEN 512, RD_LAT 1) driven from a
// scenario table, plus a small instance (LEN 16, RD_LAT 3, base FF8).
module tb_jtpang_objdma;

    logic        clk, rst_n, cen;
    logic        go0, go1, hold0;
    logic [1:0]  ak0, ak1;
    logic        busak_n0, busak_n1;
    logic        busrq_n0, busrq_n1, src_cs0, src_cs1;
    logic [11:0] src_addr0, src_addr1;
    logic [7:0]  src_dout0, src_dout1;
    logic [8:0]  obj_addr0, obj_addr1;
    logic [7:0]  obj_din0, obj_din1;
    logic        obj_we0, obj_we1, busy0, busy1;

    int nchk, nerr;
    int cyc, idx0, idx1, wr0, wr1, xfer0, xfer1, rel0, last0, last1;
    logic pwe0, pwe1, prq0;
    logic [11:0] a1;

    typedef struct {
        string name;
        int    go_clks;
        int    ack_hold;
        int    edge2;
        int    edge3;
        int    exp_xfers;
    } vec_t;
    vec_t vecs[5];

    jtpang_objdma dut0 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(go0), .busak_n(busak_n0),
        .busrq_n(busrq_n0), .src_cs(src_cs0), .src_addr(src_addr0), .src_dout(src_dout0),
        .obj_addr(obj_addr0), .obj_din(obj_din0), .obj_we(obj_we0), .busy(busy0)
    );

    jtpang_objdma #(.LEN(16), .RD_LAT(3), .SRC_BASE(12'hFF8)) dut1 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(go1), .busak_n(busak_n1),
        .busrq_n(busrq_n1), .src_cs(src_cs1), .src_addr(src_addr1), .src_dout(src_dout1),
        .obj_addr(obj_addr1), .obj_din(obj_din1), .obj_we(obj_we1), .busy(busy1)
    );

    // source RAM holds addr[7:0]
    assign src_dout0 = src_addr0[7:0];
    assign src_dout1 = src_addr1[7:0];
    assign busak_n0  = ak0[1] | hold0;
    assign busak_n1  = ak1[1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen every other clk
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cen <= 1'b0;
        else        cen <= ~cen;
    end

    // CPU answers the bus request two cen ticks later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ak0 <= 2'b11;
            ak1 <= 2'b11;
        end else if (cen) begin
            ak0 <= {ak0[0], busrq_n0};
            ak1 <= {ak1[0], busrq_n1};
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic pulse0(input int n);
        @(negedge clk);
        go0 = 1'b1;
        repeat (n) @(negedge clk);
        go0 = 1'b0;
    endtask

    task automatic wait_wr(input int target);
        for (int i = 0; i < 10000; i++) begin
            if (wr0 >= target) break;
            @(negedge clk);
        end
        chk("wait for write count", int'(wr0 >= target), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int x, w, r, bad;
        x = xfer0; w = wr0; r = rel0;
        hold0 = (v.ack_hold > 0);
        pulse0(v.go_clks);
        if (v.ack_hold > 0) begin
            for (int i = 0; i < 20 && busrq_n0; i++) @(negedge clk);
            chk({v.name, " busrq_n asserted"}, int'(busrq_n0), 0);
            bad = 0;
            repeat (v.ack_hold * 2) begin
                @(negedge clk);
                if (src_cs0 || obj_we0) bad++;
            end
            chk({v.name, " activity before ack"}, bad, 0);
            chk({v.name, " busy while waiting"}, int'(busy0), 1);
            hold0 = 1'b0;
        end
        if (v.edge2 >= 0) begin
            wait_wr(w + v.edge2);
            pulse0(4);
            chk({v.name, " busy at 2nd edge"}, int'(busy0), 1);
        end
        if (v.edge3 >= 0) begin
            wait_wr(w + v.edge3);
            pulse0(4);
        end
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if ((xfer0 - x) >= v.exp_xfers && !busy0) break;
        end
        repeat (400) @(negedge clk);
        chk({v.name, " transfers"}, xfer0 - x, v.exp_xfers);
        chk({v.name, " writes"}, wr0 - w, v.exp_xfers * 512);
        chk({v.name, " bus releases"}, rel0 - r, v.exp_xfers);
        chk({v.name, " busy idle"}, int'(busy0), 0);
        chk({v.name, " busrq_n idle"}, int'(busrq_n0), 1);
    endtask

    initial begin
        int w, bad;
        vecs[0] = '{"single",   4,    0,   -1,  -1, 1};
        vecs[1] = '{"delayack", 4,    100, -1,  -1, 1};
        vecs[2] = '{"queued",   4,    0,   200, 300, 2};
        vecs[3] = '{"held",     2000, 0,   -1,  -1, 1};
        vecs[4] = '{"oneclk",   1,    0,   -1,  -1, 1};
        nchk = 0; nerr = 0; cyc = 0;
        idx0 = 0; idx1 = 0; wr0 = 0; wr1 = 0; xfer0 = 0; xfer1 = 0; rel0 = 0;
        last0 = 0; last1 = 0; pwe0 = 1'b0; pwe1 = 1'b0; prq0 = 1'b1;
        rst_n = 1'b0; go0 = 1'b0; go1 = 1'b0; hold0 = 1'b0;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst_n) begin
                    idx0 = 0; idx1 = 0; pwe0 = 1'b0; pwe1 = 1'b0; prq0 = 1'b1;
                end else begin
                    if (obj_we0) begin
                        chk("wr0 obj_addr", int'(obj_addr0), idx0);
                        chk("wr0 obj_din", int'(obj_din0), idx0 % 256);
                        chk("wr0 pulse width", int'(pwe0), 0);
                        if (idx0 > 0) chk("wr0 byte period", cyc - last0, 4);
                        last0 = cyc; wr0++;
                        if (idx0 == 511) begin idx0 = 0; xfer0++; end
                        else idx0++;
                    end
                    if (obj_we1) begin
                        a1 = 12'hFF8 + 12'(idx1);
                        chk("wr1 src_addr", int'(src_addr1), int'(a1));
                        chk("wr1 obj_din", int'(obj_din1), int'(a1[7:0]));
                        chk("wr1 obj_addr", int'(obj_addr1), idx1);
                        if (idx1 > 0) chk("wr1 byte period", cyc - last1, 8);
                        last1 = cyc; wr1++;
                        if (idx1 == 15) begin idx1 = 0; xfer1++; end
                        else idx1++;
                    end
                    if (busrq_n0 && !prq0) rel0++;
                    pwe0 = obj_we0; pwe1 = obj_we1; prq0 = busrq_n0;
                end
            end
        join_none

        repeat (4) @(negedge clk);
        chk("reset busrq_n", int'(busrq_n0), 1);
        chk("reset src_cs", int'(src_cs0), 0);
        chk("reset src_addr", int'(src_addr0), 0);
        chk("reset src_addr base FF8", int'(src_addr1), 12'hFF8);
        chk("reset obj_addr", int'(obj_addr0), 0);
        chk("reset obj_din", int'(obj_din0), 0);
        chk("reset obj_we", int'(obj_we0), 0);
        chk("reset busy", int'(busy0), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // reset in the middle of a copy, while obj_we is high
        w = wr0;
        pulse0(4);
        wait_wr(w + 300);
        for (int i = 0; i < 20 && !obj_we0; i++) @(negedge clk);
        chk("midreset obj_we before", int'(obj_we0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busrq_n", int'(busrq_n0), 1);
        chk("midreset obj_we", int'(obj_we0), 0);
        chk("midreset busy", int'(busy0), 0);
        chk("midreset src_cs", int'(src_cs0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (3000) begin
            @(negedge clk);
            if (!busrq_n0 || obj_we0 || src_cs0 || busy0) bad++;
        end
        chk("after reset quiet", bad, 0);

        // small instance: address wrap and 4-tick cadence
        @(negedge clk);
        go1 = 1'b1;
        repeat (4) @(negedge clk);
        go1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (xfer1 >= 1 && !busy1) break;
        end
        repeat (100) @(negedge clk);
        chk("lat3 transfers", xfer1, 1);
        chk("lat3 writes", wr1, 16);
        chk("lat3 busrq_n idle", int'(busrq_n1), 1);
        chk("lat3 busy idle", int'(busy1), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
